mem_arbiter: RTL and testbench

- Two-master to one-slave arbiter for the valid/ready memory bus (valid, ready, addr, wdata, wstrb, rdata).
- Shares the chip-select decode and slave fabric between the CPU (m0) and a second bus master (m1), e.g. a DMA/blitter feeding VRAM.
- Round-robin fairness.
- Per-transaction watchdog: a slave that never answers cannot hang the bus; it is terminated with an error response.

---
 rtl/mem_bus_pkg.sv | 14 +
 rtl/bus_watchdog.sv | 26 ++
 rtl/mem_arbiter.sv | 94 +++++++++
 tb/tb_mem_arbiter.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared state encoding, grant constants and default error data
// for the valid/ready memory bus arbiter.
package mem_bus_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } state_e;

    localparam logic [1:0]  GNT_NONE     = 2'b00;
    localparam logic [1:0]  GNT_M0       = 2'b01;
    localparam logic [1:0]  GNT_M1       = 2'b10;
    localparam logic [31:0] ERR_DATA_DEF = 32'hDEADBEEF;
endpackage

// File: rtl/bus_watchdog.sv
// bus_watchdog: counts enabled cycles since the last clear and flags the
// TIMEOUT-th one; TIMEOUT = 0 builds no counter and never expires.
module bus_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic clr_i,
    output logic expire_o
);
    generate
        if (TIMEOUT == 0) begin : g_off
            assign expire_o = 1'b0;
        end else begin : g_on
            localparam int W = $clog2(TIMEOUT + 1);
            localparam logic [W-1:0] TERM = W'(TIMEOUT - 1);
            logic [W-1:0] cnt_q, cnt_d;
            always_comb cnt_d = clr_i ? '0 : en_i ? cnt_q + 1'b1 : cnt_q;
            always_ff @(posedge clk or negedge rst_n)
                if (!rst_n) cnt_q <= '0;
                else        cnt_q <= cnt_d;
            assign expire_o = en_i && (cnt_q == TERM);
        end
    endgenerate
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin two-master to one-slave valid/ready bus arbiter
// with a per-transaction watchdog that terminates stalled slaves with an error.
module mem_arbiter
    import mem_bus_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    TIMEOUT    = 255,
    parameter logic [DATA_WIDTH-1:0] ERR_DATA   = DATA_WIDTH'(ERR_DATA_DEF)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    m0_valid,
    output logic                    m0_ready,
    input  logic [ADDR_WIDTH-1:0]   m0_addr,
    input  logic [DATA_WIDTH-1:0]   m0_wdata,
    input  logic [DATA_WIDTH/8-1:0] m0_wstrb,
    output logic [DATA_WIDTH-1:0]   m0_rdata,
    input  logic                    m1_valid,
    output logic                    m1_ready,
    input  logic [ADDR_WIDTH-1:0]   m1_addr,
    input  logic [DATA_WIDTH-1:0]   m1_wdata,
    input  logic [DATA_WIDTH/8-1:0] m1_wstrb,
    output logic [DATA_WIDTH-1:0]   m1_rdata,
    output logic                    s_valid,
    input  logic                    s_ready,
    output logic [ADDR_WIDTH-1:0]   s_addr,
    output logic [DATA_WIDTH-1:0]   s_wdata,
    output logic [DATA_WIDTH/8-1:0] s_wstrb,
    input  logic [DATA_WIDTH-1:0]   s_rdata,
    output logic [1:0]              grant,
    output logic                    timeout_err,
    input  logic                    err_clr
);
    state_e     state_q, state_d;
    logic       last_q, last_d;
    logic       err_q, err_d;
    logic [1:0] grant_q, grant_d;
    logic       own0, own1, ov, done, expire, tmo;

    assign own0 = state_q == OWN0;
    assign own1 = state_q == OWN1;
    assign ov   = own0 ? m0_valid : own1 & m1_valid;
    assign done = ov & s_ready;
    assign tmo  = ov & ~s_ready & expire;

    bus_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .en_i     ((own0 | own1) & ~s_ready),
        .clr_i    (state_q == IDLE),
        .expire_o (expire)
    );

    assign s_valid     = ov;
    assign s_addr      = own0 ? m0_addr  : own1 ? m1_addr  : '0;
    assign s_wdata     = own0 ? m0_wdata : own1 ? m1_wdata : '0;
    assign s_wstrb     = own0 ? m0_wstrb : own1 ? m1_wstrb : '0;
    assign m0_ready    = own0 & (done | tmo);
    assign m1_ready    = own1 & (done | tmo);
    assign m0_rdata    = own0 ? (tmo ? ERR_DATA : s_rdata) : '0;
    assign m1_rdata    = own1 ? (tmo ? ERR_DATA : s_rdata) : '0;
    assign grant       = grant_q;
    assign timeout_err = err_q;

    // last_q = 1 means m1 owned last, so m0 wins the next tie
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        if (state_q == IDLE) begin
            if (m0_valid && (!m1_valid || last_q)) state_d = OWN0;
            else if (m1_valid)                     state_d = OWN1;
        end else if (!ov || done || tmo) begin
            state_d = IDLE;
            if (ov) last_d = own1;
        end
        grant_d = state_d == OWN0 ? GNT_M0 : state_d == OWN1 ? GNT_M1 : GNT_NONE;
        err_d   = tmo | (err_q & ~err_clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            err_q   <= 1'b0;
            grant_q <= GNT_NONE;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            err_q   <= err_d;
            grant_q <= grant_d;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus a randomized run checked against a
// transaction-level model of the arbiter (TIMEOUT = 8).
module tb_mem_arbiter;
    logic        clk = 0, rst_n = 0;
    logic        m0_valid = 0, m1_valid = 0, s_ready = 0, err_clr = 0;
    logic [31:0] m0_addr = 0, m1_addr = 0, m0_wdata = 0, m1_wdata = 0, s_rdata = 0;
    logic [3:0]  m0_wstrb = 0, m1_wstrb = 0;
    logic        m0_ready, m1_ready, s_valid, timeout_err;
    logic [31:0] m0_rdata, m1_rdata, s_addr, s_wdata;
    logic [3:0]  s_wstrb;
    logic [1:0]  grant;
    int          n_run = 0, n_fail = 0;

    mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(8), .ERR_DATA(32'hDEADBEEF)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_wstrb(m0_wstrb), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_wstrb(m1_wstrb), .m1_rdata(m1_rdata),
        .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_wstrb(s_wstrb), .s_rdata(s_rdata),
        .grant(grant), .timeout_err(timeout_err), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout sim did not finish");
        $fatal(1, "hang");
    end

    task automatic do_reset;
        rst_n = 0; m0_valid = 0; m1_valid = 0; s_ready = 0; err_clr = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
    endtask

    task automatic test_reset;
        do_reset();
        @(negedge clk); #1;
        n_run++; if (grant !== 2'b00) begin n_fail++; $display("FAIL reset_grant got %b want 00", grant); end
        n_run++; if (s_valid !== 1'b0) begin n_fail++; $display("FAIL reset_s_valid got %b want 0", s_valid); end
        n_run++; if (m0_ready !== 1'b0 || m1_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b%b want 00", m1_ready, m0_ready); end
        n_run++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", timeout_err); end
    endtask

    task automatic test_single_read;
        @(posedge clk); #1;
        m0_valid = 1; m0_addr = 32'h100; m0_wstrb = 0;
        @(negedge clk); #1;
        n_run++; if (s_valid !== 1'b0 || grant !== 2'b00) begin n_fail++; $display("FAIL sr_idle got s_valid=%b grant=%b want 0/00", s_valid, grant); end
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            s_ready = (k == 3); s_rdata = (k == 3) ? 32'h12345678 : 32'h0;
            #1;
            n_run++; if (s_valid !== 1'b1 || grant !== 2'b01 || s_addr !== 32'h100) begin n_fail++; $display("FAIL sr_own%0d got s_valid=%b grant=%b addr=%h want 1/01/00000100", k, s_valid, grant, s_addr); end
            n_run++; if (m0_ready !== (k == 3)) begin n_fail++; $display("FAIL sr_ready%0d got %b want %b", k, m0_ready, k == 3); end
            if (k == 3) begin
                n_run++; if (m0_rdata !== 32'h12345678) begin n_fail++; $display("FAIL sr_rdata got %h want 12345678", m0_rdata); end
            end
        end
        @(posedge clk); #1 m0_valid = 0; s_ready = 0;
        @(negedge clk); #1;
        n_run++; if (grant !== 2'b00 || s_valid !== 1'b0) begin n_fail++; $display("FAIL sr_after got grant=%b s_valid=%b want 00/0", grant, s_valid); end
    endtask

    task automatic test_back_to_back;
        int i0, i1, nc, cyc;
        logic o;
        do_reset();
        i0 = 0; i1 = 0; nc = 0; cyc = 0;
        m0_valid = 1; m1_valid = 1; m0_wstrb = 4'hF; m1_wstrb = 4'hF;
        m0_addr = 32'h400; m1_addr = 32'h800;
        m0_wdata = 32'hA0000000; m1_wdata = 32'hB0000000;
        while ((i0 < 4 || i1 < 4) && cyc < 60) begin
            @(negedge clk); s_ready = s_valid; #1; cyc++;
            if (m0_ready || m1_ready) begin
                o = m1_ready;
                n_run++; if (o !== nc[0] || grant !== (o ? 2'b10 : 2'b01) || (m0_ready && m1_ready)) begin n_fail++; $display("FAIL b2b_order%0d got m%0d grant=%b want m%0d", nc, o, grant, nc[0]); end
                n_run++; if (s_wdata !== (o ? 32'hB0000000 + i1 : 32'hA0000000 + i0)) begin n_fail++; $display("FAIL b2b_wdata%0d got %h want %h", nc, s_wdata, o ? 32'hB0000000 + i1 : 32'hA0000000 + i0); end
                nc++;
                @(posedge clk); #1;
                if (o) begin i1++; m1_wdata = 32'hB0000000 + i1; if (i1 == 4) m1_valid = 0; end
                else   begin i0++; m0_wdata = 32'hA0000000 + i0; if (i0 == 4) m0_valid = 0; end
            end
        end
        s_ready = 0;
        n_run++; if (i0 != 4 || i1 != 4) begin n_fail++; $display("FAIL b2b_count got %0d/%0d want 4/4", i0, i1); end
    endtask

    task automatic test_no_preempt;
        @(posedge clk); #1;
        m1_valid = 1; m1_addr = 32'h2000; m1_wdata = 32'h5555AAAA; m1_wstrb = 4'hF; s_ready = 0;
        @(posedge clk); #1;
        m0_valid = 1; m0_addr = 32'h3000; m0_wstrb = 0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk); s_ready = (k == 6); #1;
            n_run++; if (grant !== 2'b10 || m0_ready !== 1'b0 || m1_ready !== (k == 6) || s_wdata !== 32'h5555AAAA) begin n_fail++; $display("FAIL np_own%0d got grant=%b m0r=%b m1r=%b wdata=%h want 10/0/%b/5555aaaa", k, grant, m0_ready, m1_ready, s_wdata, k == 6); end
        end
        @(posedge clk); #1 m1_valid = 0; s_ready = 0;
        @(negedge clk); #1;
        n_run++; if (grant !== 2'b00 || m0_ready !== 1'b0) begin n_fail++; $display("FAIL np_dead got grant=%b m0r=%b want 00/0", grant, m0_ready); end
        @(negedge clk); s_ready = 1; #1;
        n_run++; if (grant !== 2'b01 || m0_ready !== 1'b1 || s_addr !== 32'h3000) begin n_fail++; $display("FAIL np_m0 got grant=%b m0r=%b addr=%h want 01/1/00003000", grant, m0_ready, s_addr); end
        @(posedge clk); #1 m0_valid = 0; s_ready = 0;
    endtask

    task automatic test_timeout;
        @(posedge clk); #1;
        m0_valid = 1; m0_addr = 32'h00007000; m0_wstrb = 0; s_ready = 0;
        @(negedge clk);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk); #1;
            n_run++; if (grant !== 2'b01 || m0_ready !== (k == 8)) begin n_fail++; $display("FAIL to_own%0d got grant=%b m0r=%b want 01/%b", k, grant, m0_ready, k == 8); end
            if (k == 8) begin
                n_run++; if (m0_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL to_rdata got %h want deadbeef", m0_rdata); end
            end
        end
        @(posedge clk); #1 m0_valid = 0;
        @(negedge clk); #1;
        n_run++; if (timeout_err !== 1'b1 || grant !== 2'b00) begin n_fail++; $display("FAIL to_err got err=%b grant=%b want 1/00", timeout_err, grant); end
        repeat (3) @(negedge clk); #1;
        n_run++; if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL to_sticky got %b want 1", timeout_err); end
        @(posedge clk); #1 err_clr = 1;
        @(posedge clk); #1 err_clr = 0;
        @(negedge clk); #1;
        n_run++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL to_clr got %b want 0", timeout_err); end
        @(posedge clk); #1 m0_valid = 1;
        @(negedge clk);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 8) err_clr = 1;
        end
        @(posedge clk); #1 err_clr = 0; m0_valid = 0;
        @(negedge clk); #1;
        n_run++; if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL to_clr_race got %b want 1", timeout_err); end
        @(posedge clk); #1 err_clr = 1;
        @(posedge clk); #1 err_clr = 0;
    endtask

    task automatic test_coincident;
        @(posedge clk); #1;
        m0_valid = 1; m0_addr = 32'h00007004; m0_wstrb = 0; s_ready = 0;
        @(negedge clk);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk); s_ready = (k == 8); s_rdata = 32'hCAFEF00D; #1;
            n_run++; if (m0_ready !== (k == 8)) begin n_fail++; $display("FAIL co_ready%0d got %b want %b", k, m0_ready, k == 8); end
            if (k == 8) begin
                n_run++; if (m0_rdata !== 32'hCAFEF00D) begin n_fail++; $display("FAIL co_rdata got %h want cafef00d", m0_rdata); end
            end
        end
        @(posedge clk); #1 m0_valid = 0; s_ready = 0;
        @(negedge clk); #1;
        n_run++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL co_err got %b want 0", timeout_err); end
    endtask

    task automatic test_async_reset;
        @(posedge clk); #1;
        m1_valid = 1; m1_addr = 32'h9000; m1_wstrb = 0; s_ready = 0;
        @(negedge clk);
        @(negedge clk); #1;
        n_run++; if (grant !== 2'b10) begin n_fail++; $display("FAIL ar_own got %b want 10", grant); end
        @(negedge clk); #2;
        s_ready = 1; rst_n = 0;
        #1;
        n_run++; if (grant !== 2'b00 || s_valid !== 1'b0 || m1_ready !== 1'b0) begin n_fail++; $display("FAIL ar_async got grant=%b s_valid=%b m1r=%b want 00/0/0", grant, s_valid, m1_ready); end
        s_ready = 0; m0_valid = 1; m0_addr = 32'hA000;
        @(posedge clk); #1 rst_n = 1;
        @(negedge clk); #1;
        n_run++; if (grant !== 2'b00) begin n_fail++; $display("FAIL ar_idle got %b want 00", grant); end
        @(negedge clk); s_ready = 1; #1;
        n_run++; if (grant !== 2'b01 || m0_ready !== 1'b1) begin n_fail++; $display("FAIL ar_tie got grant=%b m0r=%b want 01/1", grant, m0_ready); end
        @(posedge clk); #1 m0_valid = 0; m1_valid = 0; s_ready = 0;
    endtask

    task automatic test_random;
        logic [31:0] a[2], d[2];
        logic [3:0]  st[2];
        bit          pend[2], dn[2];
        int          issued[2], compl[2], wcnt;
        bit          last, was_idle, o;
        logic [1:0]  ipend, eg;
        do_reset();
        last = 1; was_idle = 0; wcnt = 0;
        for (int i = 0; i < 2; i++) begin pend[i] = 0; dn[i] = 0; issued[i] = 0; compl[i] = 0; end
        for (int cyc = 0; cyc < 640; cyc++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 2; i++) begin
                if (dn[i]) begin pend[i] = 0; dn[i] = 0; end
                if (!pend[i] && cyc < 600 && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1; a[i] = $urandom & 32'hFFFFFFFC; d[i] = $urandom;
                    st[i] = 4'($urandom); issued[i]++;
                end
            end
            m0_valid = pend[0]; m0_addr = a[0]; m0_wdata = d[0]; m0_wstrb = st[0];
            m1_valid = pend[1]; m1_addr = a[1]; m1_wdata = d[1]; m1_wstrb = st[1];
            @(negedge clk);
            if (s_valid && (wcnt >= 4 || $urandom_range(0, 1) == 1)) begin s_ready = 1; wcnt = 0; end
            else begin s_ready = 0; if (s_valid) wcnt++; end
            s_rdata = s_addr ^ 32'h5A5AA5A5;
            #1;
            if (grant == 2'b00) begin
                n_run++; if (s_valid !== 1'b0 || m0_ready !== 1'b0 || m1_ready !== 1'b0) begin n_fail++; $display("FAIL rnd_idle%0d got s_valid=%b ready=%b%b want 0/00", cyc, s_valid, m1_ready, m0_ready); end
                ipend = {pend[1], pend[0]}; was_idle = 1;
            end else begin
                o = grant[1];
                if (was_idle) begin
                    eg = (ipend == 2'b11) ? (last ? 2'b01 : 2'b10) : ipend;
                    n_run++; if (grant !== eg) begin n_fail++; $display("FAIL rnd_arb%0d got %b want %b", cyc, grant, eg); end
                    was_idle = 0;
                end
                n_run++; if (s_valid !== 1'b1 || s_addr !== a[o] || s_wdata !== d[o] || s_wstrb !== st[o]) begin n_fail++; $display("FAIL rnd_mux%0d got %b %h %h %h want 1 %h %h %h", cyc, s_valid, s_addr, s_wdata, s_wstrb, a[o], d[o], st[o]); end
                n_run++;
                if ((o ? m1_ready : m0_ready) !== s_ready || (o ? m0_ready : m1_ready) !== 1'b0
                    || (o ? m0_rdata : m1_rdata) !== 32'h0 || (o ? m1_rdata : m0_rdata) !== (a[o] ^ 32'h5A5AA5A5)) begin
                    n_fail++; $display("FAIL rnd_resp%0d got ready=%b%b rdata0=%h rdata1=%h want owner m%0d ready=%b rdata=%h", cyc, m1_ready, m0_ready, m0_rdata, m1_rdata, o, s_ready, a[o] ^ 32'h5A5AA5A5);
                end
                if (s_ready) begin dn[o] = 1; last = o; compl[o]++; end
            end
        end
        s_ready = 0;
        n_run++; if (issued[0] != compl[0] || issued[1] != compl[1]) begin n_fail++; $display("FAIL rnd_count got %0d/%0d want %0d/%0d", compl[0], compl[1], issued[0], issued[1]); end
        @(posedge clk); #1 m0_valid = 0; m1_valid = 0;
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_back_to_back();
        test_no_preempt();
        test_timeout();
        test_coincident();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
